cook_countdown_timer: RTL and testbench

- Downstream stage of the egg-timer control FSM. It captures the MM:SS BCD digits the FSM has set, counts them down at 1 Hz once started, and drives the alarm.
- Its one-cycle cook_done pulse is the FSM's cook_time input, which returns the FSM to the set-time state.
- Runs on the system clock and uses a one-cycle 1 Hz enable from the clock divider. It does not use a derived clock.

---
 rtl/egg_timer_pkg.sv | 21 ++
 rtl/cook_countdown_timer_if.sv | 34 +++
 rtl/bcd_digit_down.sv | 29 ++
 rtl/cook_countdown_timer.sv | 127 ++++++++++++
 tb/tb_cook_countdown_timer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/egg_timer_pkg.sv
// Shared types and constants for the egg-timer countdown stage.
package egg_timer_pkg;

  localparam int unsigned BCD_W            = 4;
  localparam int unsigned BCD_ONES_MAX     = 9;
  localparam int unsigned SEC_TENS_MAX_DEF = 5;
  localparam int unsigned MIN_TENS_MAX_DEF = 9;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bcd_t bcd_clamp(input bcd_t val, input bcd_t max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/cook_countdown_timer_if.sv
// Control, load-digit and status signals between the egg-timer FSM side and the countdown stage.
interface cook_countdown_timer_if;
  import egg_timer_pkg::*;

  logic tick_1hz;
  logic load;
  logic start;
  logic cancel;
  logic ack;
  bcd_t load_min_tens;
  bcd_t load_min_ones;
  bcd_t load_sec_tens;
  bcd_t load_sec_ones;
  bcd_t min_tens;
  bcd_t min_ones;
  bcd_t sec_tens;
  bcd_t sec_ones;
  logic running;
  logic cook_done;
  logic alarm;

  modport master (
    output tick_1hz, load, start, cancel, ack,
    output load_min_tens, load_min_ones, load_sec_tens, load_sec_ones,
    input  min_tens, min_ones, sec_tens, sec_ones, running, cook_done, alarm
  );

  modport slave (
    input  tick_1hz, load, start, cancel, ack,
    input  load_min_tens, load_min_ones, load_sec_tens, load_sec_ones,
    output min_tens, min_ones, sec_tens, sec_ones, running, cook_done, alarm
  );

endinterface

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with load and a combinational borrow chain.
module bcd_digit_down
  import egg_timer_pkg::*;
#(
  parameter bcd_t WRAP_VAL = bcd_t'(BCD_ONES_MAX)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  bcd_t load_val,
  input  logic dec_en,
  input  logic borrow_in,
  output bcd_t digit,
  output logic borrow_out
);

  assign borrow_out = borrow_in && (digit == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (dec_en && borrow_in) begin
      digit <= (digit == '0) ? WRAP_VAL : digit - bcd_t'(1);
    end
  end

endmodule

// File: rtl/cook_countdown_timer.sv
// MM:SS BCD countdown with start/cancel, one-cycle cook_done and alarm.
// Optional ALARM_TIMEOUT_EN: alarm auto-clears after ALARM_TICKS ticks in DONE.
module cook_countdown_timer
  import egg_timer_pkg::*;
#(
  parameter int unsigned MIN_TENS_MAX = MIN_TENS_MAX_DEF,
  parameter int unsigned SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter int unsigned ALARM_TICKS  = 10
) (
  input logic clk,
  input logic reset,
  cook_countdown_timer_if.slave bus
);

  if (ALARM_TICKS < 1) begin : g_bad_alarm_ticks
    $error("ALARM_TICKS must be at least 1");
  end

  state_t state;
  logic   running_q, cook_done_q, alarm_q;
  bcd_t   mt, mo, st, so;
  bcd_t   ld_mt, ld_mo, ld_st, ld_so;
  logic   so_b, st_b, mo_b, mt_b;
  logic   load_dig, dec_en, count_zero, at_one;

  assign ld_mt = bcd_clamp(bus.load_min_tens, bcd_t'(MIN_TENS_MAX));
  assign ld_mo = bcd_clamp(bus.load_min_ones, bcd_t'(BCD_ONES_MAX));
  assign ld_st = bcd_clamp(bus.load_sec_tens, bcd_t'(SEC_TENS_MAX));
  assign ld_so = bcd_clamp(bus.load_sec_ones, bcd_t'(BCD_ONES_MAX));

  // The full borrow chain ripples out of min_tens only when every digit is zero.
  assign count_zero = mt_b;
  assign at_one     = (mt == '0) && (mo == '0) && (st == '0) && (so == bcd_t'(1));
  assign load_dig   = bus.load && (state != RUN);
  assign dec_en     = (state == RUN) && bus.tick_1hz && !bus.cancel && !count_zero;

  bcd_digit_down #(.WRAP_VAL(bcd_t'(BCD_ONES_MAX))) u_sec_ones (
    .clk(clk), .reset(reset), .load(load_dig), .load_val(ld_so),
    .dec_en(dec_en), .borrow_in(1'b1), .digit(so), .borrow_out(so_b)
  );

  bcd_digit_down #(.WRAP_VAL(bcd_t'(SEC_TENS_MAX))) u_sec_tens (
    .clk(clk), .reset(reset), .load(load_dig), .load_val(ld_st),
    .dec_en(dec_en), .borrow_in(so_b), .digit(st), .borrow_out(st_b)
  );

  bcd_digit_down #(.WRAP_VAL(bcd_t'(BCD_ONES_MAX))) u_min_ones (
    .clk(clk), .reset(reset), .load(load_dig), .load_val(ld_mo),
    .dec_en(dec_en), .borrow_in(st_b), .digit(mo), .borrow_out(mo_b)
  );

  bcd_digit_down #(.WRAP_VAL(bcd_t'(MIN_TENS_MAX))) u_min_tens (
    .clk(clk), .reset(reset), .load(load_dig), .load_val(ld_mt),
    .dec_en(dec_en), .borrow_in(mo_b), .digit(mt), .borrow_out(mt_b)
  );

`ifdef ALARM_TIMEOUT_EN
  localparam int unsigned ACW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  logic [ACW-1:0] alarm_cnt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      running_q   <= 1'b0;
      cook_done_q <= 1'b0;
      alarm_q     <= 1'b0;
`ifdef ALARM_TIMEOUT_EN
      alarm_cnt   <= '0;
`endif
    end else begin
      cook_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.load && bus.start && !count_zero) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.cancel) begin
            state     <= IDLE;
            running_q <= 1'b0;
          end else if (bus.tick_1hz && at_one) begin
            state       <= DONE;
            running_q   <= 1'b0;
            cook_done_q <= 1'b1;
            alarm_q     <= 1'b1;
`ifdef ALARM_TIMEOUT_EN
            alarm_cnt   <= '0;
`endif
          end
        end
        DONE: begin
          if (bus.ack || bus.load) begin
            state   <= IDLE;
            alarm_q <= 1'b0;
          end
`ifdef ALARM_TIMEOUT_EN
          else if (bus.tick_1hz) begin
            if (alarm_cnt == ACW'(ALARM_TICKS - 1)) begin
              state   <= IDLE;
              alarm_q <= 1'b0;
            end else begin
              alarm_cnt <= alarm_cnt + ACW'(1);
            end
          end
`endif
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
          alarm_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.min_tens  = mt;
  assign bus.min_ones  = mo;
  assign bus.sec_tens  = st;
  assign bus.sec_ones  = so;
  assign bus.running   = running_q;
  assign bus.cook_done = cook_done_q;
  assign bus.alarm     = alarm_q;

endmodule

// File: tb/tb_cook_countdown_timer.sv
// Table-driven scoreboard bench for cook_countdown_timer (default and ALARM_TIMEOUT_EN builds).
module tb_cook_countdown_timer;
  import egg_timer_pkg::*;

  typedef struct packed {
    logic [15:0] digits;
    logic        run;
    logic        done;
    logic        alarm;
  } obs_t;

  typedef struct {
    logic        ld, st, ca, ak, tk;
    logic [15:0] ldv;
    obs_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cook_countdown_timer_if bus ();

  cook_countdown_timer #(.ALARM_TICKS(3)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  obs_t sbq[$];
  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;

  function automatic obs_t ob(input logic [15:0] d, input logic r, input logic dn, input logic a);
    obs_t o;
    o.digits = d;
    o.run    = r;
    o.done   = dn;
    o.alarm  = a;
    return o;
  endfunction

  function automatic vec_t mk(input logic ld, input logic st, input logic ca, input logic ak,
                              input logic tk, input logic [15:0] ldv, input logic [15:0] ed,
                              input logic r, input logic dn, input logic a);
    vec_t v;
    v.ld  = ld;
    v.st  = st;
    v.ca  = ca;
    v.ak  = ak;
    v.tk  = tk;
    v.ldv = ldv;
    v.exp = ob(ed, r, dn, a);
    return v;
  endfunction

  function automatic obs_t read_dut();
    return ob({bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones},
              bus.running, bus.cook_done, bus.alarm);
  endfunction

  task automatic check(input string nm, input obs_t act, input obs_t exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h run=%b done=%b alarm=%b, expected %h run=%b done=%b alarm=%b",
               nm, act.digits, act.run, act.done, act.alarm,
               exp.digits, exp.run, exp.done, exp.alarm);
    end
  endtask

  task automatic idle_inputs();
    bus.tick_1hz = 1'b0;
    bus.load     = 1'b0;
    bus.start    = 1'b0;
    bus.cancel   = 1'b0;
    bus.ack      = 1'b0;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare #1 after the edge.
  task automatic apply(input string nm, input vec_t v);
    obs_t exp;
    bus.load          = v.ld;
    bus.start         = v.st;
    bus.cancel        = v.ca;
    bus.ack           = v.ak;
    bus.tick_1hz      = v.tk;
    bus.load_min_tens = v.ldv[15:12];
    bus.load_min_ones = v.ldv[11:8];
    bus.load_sec_tens = v.ldv[7:4];
    bus.load_sec_ones = v.ldv[3:0];
    sbq.push_back(v.exp);
    @(posedge clk);
    #1;
    idle_inputs();
    if (sbq.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      exp = sbq.pop_front();
      check(nm, read_dut(), exp);
    end
  endtask

  initial begin
    idle_inputs();
    bus.load_min_tens = '0;
    bus.load_min_ones = '0;
    bus.load_sec_tens = '0;
    bus.load_sec_ones = '0;
    reset = 1'b1;

    //        ld st ca ak tk  load      expect    r  d  a
    // 01:05 countdown with minute borrow
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0105, 16'h0105, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0105, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0104, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0103, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0102, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0101, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0100, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0059, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0059, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0059, 0, 0, 0));
    // 00:02 to completion, DONE holds, ack exits
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0002, 16'h0002, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));
    // clamping on capture, 99:59 -> 99:58
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'hCF8F, 16'h9959, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h9959, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h9958, 1, 0, 0));
    // cancel beats tick, resume, load ignored in RUN
    tbl.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h9958, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0030, 16'h0030, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0030, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 16'h0030, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0030, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0029, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 16'h0500, 16'h0028, 1, 0, 0));
    // start at 00:00 ignored; load+start captures only
    tbl.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0028, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 16'h1234, 16'h1234, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h1234, 0, 0, 0));
    // tick coincident with start is not counted
    tbl.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 16'h1234, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h1233, 1, 0, 0));
    // DONE exited by load, which captures
    tbl.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h1233, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0001, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0742, 16'h0742, 0, 0, 0));
    // borrow through three digits: 10:00 -> 09:59
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h1000, 16'h1000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h1000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0959, 1, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", read_dut(), ob(16'h0000, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset_release", read_dut(), ob(16'h0000, 0, 0, 0));

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // Alarm behaviour with ticks arriving while in DONE
    apply("alm_cancel", mk(0, 0, 1, 0, 0, 16'h0000, 16'h0959, 0, 0, 0));
    apply("alm_load",   mk(1, 0, 0, 0, 0, 16'h0001, 16'h0001, 0, 0, 0));
    apply("alm_start",  mk(0, 1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0));
    apply("alm_finish", mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1));
    apply("alm_tick1",  mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1));
    apply("alm_gap",    mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1));
    apply("alm_tick2",  mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1));
`ifdef ALARM_TIMEOUT_EN
    apply("alm_tick3_timeout", mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0));
    apply("alm_idle_after",    mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0));
`else
    apply("alm_tick3_hold",    mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1));
    apply("alm_tick4_hold",    mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1));
    apply("alm_ack",           mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));
`endif

    // Asynchronous reset in the middle of RUN
    apply("rst_load",  mk(1, 0, 0, 0, 0, 16'h0105, 16'h0105, 0, 0, 0));
    apply("rst_start", mk(0, 1, 0, 0, 0, 16'h0000, 16'h0105, 1, 0, 0));
    apply("rst_tick",  mk(0, 0, 0, 0, 1, 16'h0000, 16'h0104, 1, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_mid_run", read_dut(), ob(16'h0000, 0, 0, 0));
    bus.tick_1hz = 1'b1;
    @(posedge clk);
    #1;
    check("reset_held_with_tick", read_dut(), ob(16'h0000, 0, 0, 0));
    bus.tick_1hz = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    apply("post_reset_start_zero", mk(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));

    if (sbq.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sbq.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
